// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush sequencer for the 5-stage pipeline: operand forwarding, load-use stall,
// branch flush and data-memory wait freeze with timeout. Optional counters under STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MWAIT_MAX = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       d_use_rs,
  input  logic       d_use_rt,
  input  logic       d_brtaken,
  input  logic       e_wreg,
  input  logic       e_m2reg,
  input  logic [4:0] e_rn,
  input  logic       m_wreg,
  input  logic       m_m2reg,
  input  logic [4:0] m_rn,
  input  logic       mem_busy,
  output logic       wpcir,
  output logic       fd_flush,
  output logic       de_en,
  output logic       de_bubble,
  output logic       em_en,
  output logic       mw_en,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       err,
  output logic [1:0] state
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mw_cnt,
  output logic [CNT_W-1:0] fl_cnt
`endif
);

  localparam int unsigned WCNT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_MWAIT = 2'b01,
    ST_ERR   = 2'b10
  } state_t;

  state_t              cur_st, nxt_st;
  logic [WCNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                err_nxt;
  logic                freeze;
  logic                run_out;
  logic                lu;

  // EXE ALU result beats MEM; a load still in EXE cannot forward
  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input logic ew, input logic em2, input logic [4:0] ern,
                                         input logic mw, input logic mm2, input logic [4:0] mrn);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_r && r != 5'd0) begin
      if (ew && !em2 && ern == r) sel = 2'b01;
      else if (mw && mrn == r)    sel = mm2 ? 2'b11 : 2'b10;
    end
    return sel;
  endfunction

  assign state = cur_st;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cur_st   <= ST_RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      cur_st   <= nxt_st;
      wait_cnt <= wait_cnt_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    nxt_st       = cur_st;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = err;
    freeze       = 1'b0;
    run_out      = 1'b0;
    wpcir        = 1'b1;
    fd_flush     = 1'b0;
    de_en        = 1'b1;
    de_bubble    = 1'b0;
    em_en        = 1'b1;
    mw_en        = 1'b1;
    fwda         = fwd_sel(d_use_rs, d_rs, e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn);
    fwdb         = fwd_sel(d_use_rt, d_rt, e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn);
    lu           = e_wreg && e_m2reg && (e_rn != 5'd0) &&
                   ((d_use_rs && d_rs == e_rn) || (d_use_rt && d_rt == e_rn));

    if (!resetn) begin
      fwda = 2'b00;
      fwdb = 2'b00;
    end else begin
      case (cur_st)
        ST_RUN: begin
          if (mem_busy) begin
            freeze       = 1'b1;
            nxt_st       = ST_MWAIT;
            wait_cnt_nxt = WCNT_W'(1);
          end else begin
            run_out = 1'b1;
          end
        end
        ST_MWAIT: begin
          if (mem_busy) begin
            freeze = 1'b1;
            if (wait_cnt == WCNT_W'(MWAIT_MAX)) begin
              nxt_st  = ST_ERR;
              err_nxt = 1'b1;
            end else begin
              wait_cnt_nxt = wait_cnt + WCNT_W'(1);
            end
          end else begin
            run_out      = 1'b1;
            nxt_st       = ST_RUN;
            wait_cnt_nxt = '0;
          end
        end
        ST_ERR: begin
          freeze  = 1'b1;
          err_nxt = 1'b1;
        end
        default: begin
          nxt_st       = ST_RUN;
          wait_cnt_nxt = '0;
        end
      endcase

      // stall wins over flush: the branch is re-resolved after the bubble
      if (freeze) begin
        wpcir = 1'b0;
        de_en = 1'b0;
        em_en = 1'b0;
        mw_en = 1'b0;
      end else if (run_out) begin
        if (lu) begin
          wpcir     = 1'b0;
          de_bubble = 1'b1;
        end else begin
          fd_flush  = d_brtaken;
        end
      end
    end
  end

`ifdef STALL_CNT_EN
  // de_bubble marks a load-use stall, de_en=0 marks a freeze cycle
  always_ff @(posedge clock) begin
    if (!resetn) begin
      lu_cnt <= '0;
      mw_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      if (de_bubble && lu_cnt != '1) lu_cnt <= lu_cnt + CNT_W'(1);
      if (!de_en && mw_cnt != '1)    mw_cnt <= mw_cnt + CNT_W'(1);
      if (fd_flush && fl_cnt != '1)  fl_cnt <= fl_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^32'(CNT_W);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model. Counter checks compile in under STALL_CNT_EN.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MWAIT_MAX = 16;
  localparam int unsigned CNT_W     = 4;

  logic       clock = 1'b0;
  logic       resetn;
  logic [4:0] d_rs, d_rt, e_rn, m_rn;
  logic       d_use_rs, d_use_rt, d_brtaken;
  logic       e_wreg, e_m2reg, m_wreg, m_m2reg, mem_busy;
  logic       wpcir, fd_flush, de_en, de_bubble, em_en, mw_en, err;
  logic [1:0] fwda, fwdb, state;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] lu_cnt, mw_cnt, fl_cnt;
`endif

  typedef struct packed {
    logic       wpcir;
    logic       fd_flush;
    logic       de_en;
    logic       de_bubble;
    logic       em_en;
    logic       mw_en;
    logic [1:0] fwda;
    logic [1:0] fwdb;
    logic       err;
    logic [1:0] state;
  } obs_t;

  int n_checks = 0;
  int n_fail   = 0;

  // model: length of the current busy run and a sticky error flag
  int busy_run;
  bit in_err;

  pipe_hazard_ctrl #(.MWAIT_MAX(MWAIT_MAX), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_brtaken(d_brtaken),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn),
    .mem_busy(mem_busy),
    .wpcir(wpcir), .fd_flush(fd_flush), .de_en(de_en), .de_bubble(de_bubble),
    .em_en(em_en), .mw_en(mw_en), .fwda(fwda), .fwdb(fwdb), .err(err), .state(state)
`ifdef STALL_CNT_EN
    , .lu_cnt(lu_cnt), .mw_cnt(mw_cnt), .fl_cnt(fl_cnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic obs_t observed();
    return '{wpcir, fd_flush, de_en, de_bubble, em_en, mw_en, fwda, fwdb, err, state};
  endfunction

  function automatic logic [1:0] ref_fwd(input logic use_r, input logic [4:0] r);
    if (!use_r || r == 5'd0) return 2'b00;
    if (e_wreg && e_rn == r && !e_m2reg) return 2'b01;
    if (m_wreg && m_rn == r) return m_m2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  function automatic obs_t expected();
    obs_t o;
    logic frozen, stall;
    o.err   = in_err;
    o.state = in_err ? 2'b10 : (busy_run > 0 ? 2'b01 : 2'b00);
    o.fwda  = resetn ? ref_fwd(d_use_rs, d_rs) : 2'b00;
    o.fwdb  = resetn ? ref_fwd(d_use_rt, d_rt) : 2'b00;
    frozen  = resetn && (in_err || mem_busy);
    stall   = resetn && !frozen && e_wreg && e_m2reg && e_rn != 5'd0 &&
              ((d_use_rs && d_rs == e_rn) || (d_use_rt && d_rt == e_rn));
    o.de_en     = !frozen;
    o.em_en     = !frozen;
    o.mw_en     = !frozen;
    o.wpcir     = !frozen && !stall;
    o.de_bubble = stall;
    o.fd_flush  = resetn && !frozen && !stall && d_brtaken;
    return o;
  endfunction

  // advance one clock edge and update the model from the inputs sampled there
  task automatic tick();
    @(posedge clock);
    if (!resetn) begin
      busy_run = 0;
      in_err   = 1'b0;
    end else if (!in_err) begin
      if (mem_busy) begin
        busy_run++;
        if (busy_run > int'(MWAIT_MAX)) in_err = 1'b1;
      end else begin
        busy_run = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    d_rs = 5'd0; d_rt = 5'd0; d_use_rs = 1'b0; d_use_rt = 1'b0; d_brtaken = 1'b0;
    e_wreg = 1'b0; e_m2reg = 1'b0; e_rn = 5'd0;
    m_wreg = 1'b0; m_m2reg = 1'b0; m_rn = 5'd0; mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    obs_t a, x;
    idle_inputs();
    resetn = 1'b0;
    busy_run = 0; in_err = 1'b0;
    tick(); tick();
    // hazards and busy asserted during reset must not leak to the outputs
    mem_busy = 1'b1; d_brtaken = 1'b1; e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd5;
    d_rs = 5'd5; d_use_rs = 1'b1; m_wreg = 1'b1; m_rn = 5'd5;
    @(negedge clock);
    a = observed();
    x = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00};
    n_checks++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL reset_forced: got %h expected %h", a, x);
    end
    tick();
    idle_inputs();
    resetn = 1'b1;
  endtask

  task automatic test_load_use();
    idle_inputs();
    e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd5; d_rs = 5'd5; d_use_rs = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({wpcir, de_bubble, de_en, fd_flush} !== 4'b0110) begin
      n_fail++;
      $display("FAIL load_use_stall: got wpcir/bubble/de_en/flush=%b expected 0110",
               {wpcir, de_bubble, de_en, fd_flush});
    end
    tick();
    // the load moves to MEM, a bubble now sits in EXE
    e_wreg = 1'b0; e_m2reg = 1'b0; e_rn = 5'd0;
    m_wreg = 1'b1; m_m2reg = 1'b1; m_rn = 5'd5;
    @(negedge clock);
    n_checks++;
    if ({wpcir, de_bubble, fwda} !== 4'b1011) begin
      n_fail++;
      $display("FAIL load_use_resume: got wpcir/bubble/fwda=%b expected 1011",
               {wpcir, de_bubble, fwda});
    end
    tick();
  endtask

  task automatic test_forwarding();
    idle_inputs();
    e_wreg = 1'b1; e_rn = 5'd3; m_wreg = 1'b1; m_m2reg = 1'b1; m_rn = 5'd3;
    d_rt = 5'd3; d_use_rt = 1'b1;
    @(negedge clock);
    n_checks++;
    if (fwdb !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_exe_priority: got fwdb=%b expected 01", fwdb);
    end
    tick();
    e_rn = 5'd0; m_rn = 5'd0; d_rt = 5'd0;
    @(negedge clock);
    n_checks++;
    if (fwdb !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_r0: got fwdb=%b expected 00", fwdb);
    end
    tick();
    e_wreg = 1'b0; m_m2reg = 1'b0; m_rn = 5'd9; d_rs = 5'd9; d_use_rs = 1'b1;
    @(negedge clock);
    n_checks++;
    if (fwda !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_mem_alu: got fwda=%b expected 10", fwda);
    end
    tick();
  endtask

  task automatic test_branch();
    idle_inputs();
    d_brtaken = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({fd_flush, wpcir, de_bubble} !== 3'b110) begin
      n_fail++;
      $display("FAIL branch_flush: got flush/wpcir/bubble=%b expected 110",
               {fd_flush, wpcir, de_bubble});
    end
    tick();
    e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd7; d_rt = 5'd7; d_use_rt = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({fd_flush, wpcir, de_bubble} !== 3'b001) begin
      n_fail++;
      $display("FAIL branch_vs_stall: got flush/wpcir/bubble=%b expected 001",
               {fd_flush, wpcir, de_bubble});
    end
    tick();
  endtask

  task automatic test_mem_wait();
    obs_t a, x;
    idle_inputs();
    d_brtaken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_busy = (i < 3);
      @(negedge clock);
      a = observed();
      x = expected();
      n_checks++;
      if (a !== x) begin
        n_fail++;
        $display("FAIL mem_wait_cyc%0d: got %h expected %h", i, a, x);
      end
      tick();
    end
    @(negedge clock);
    n_checks++;
    if ({state, err, de_en} !== 4'b0001) begin
      n_fail++;
      $display("FAIL mem_wait_exit: got state/err/de_en=%b expected 0001", {state, err, de_en});
    end
  endtask

  task automatic test_timeout();
    idle_inputs();
    mem_busy = 1'b1;
    for (int i = 0; i < int'(MWAIT_MAX); i++) tick();
    @(negedge clock);
    n_checks++;
    if ({state, err} !== 3'b010) begin
      n_fail++;
      $display("FAIL timeout_edge: got state/err=%b expected 010", {state, err});
    end
    tick();
    mem_busy = 1'b0;
    tick(); tick();
    @(negedge clock);
    n_checks++;
    if ({state, err, wpcir, de_en, em_en, mw_en} !== 7'b1010000) begin
      n_fail++;
      $display("FAIL timeout_lock: got state/err/enables=%b expected 1010000",
               {state, err, wpcir, de_en, em_en, mw_en});
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({state, err, de_en} !== 4'b0001) begin
      n_fail++;
      $display("FAIL timeout_reset: got state/err/de_en=%b expected 0001", {state, err, de_en});
    end
    tick();
  endtask

  task automatic test_random();
    obs_t a, x;
    for (int i = 0; i < 600; i++) begin
      resetn    = ($urandom_range(0, 49) != 0);
      d_rs      = 5'($urandom_range(0, 3));
      d_rt      = 5'($urandom_range(0, 3));
      e_rn      = 5'($urandom_range(0, 3));
      m_rn      = 5'($urandom_range(0, 3));
      d_use_rs  = 1'($urandom);
      d_use_rt  = 1'($urandom);
      d_brtaken = 1'($urandom);
      e_wreg    = 1'($urandom);
      e_m2reg   = 1'($urandom);
      m_wreg    = 1'($urandom);
      m_m2reg   = 1'($urandom);
      mem_busy  = (i % 200 > 150) ? 1'b1 : ($urandom_range(0, 4) == 0);
      @(negedge clock);
      a = observed();
      x = expected();
      n_checks++;
      if (a !== x) begin
        n_fail++;
        $display("FAIL random_%0d: got %h expected %h", i, a, x);
      end
      tick();
    end
    resetn = 1'b0;
    idle_inputs();
    tick();
    resetn = 1'b1;
  endtask

`ifdef STALL_CNT_EN
  task automatic test_counters();
    idle_inputs();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd5; d_rs = 5'd5; d_use_rs = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    idle_inputs();
    d_brtaken = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    d_brtaken = 1'b0;
    mem_busy = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    mem_busy = 1'b0;
    tick();
    @(negedge clock);
    n_checks++;
    if ({lu_cnt, fl_cnt, mw_cnt} !== {4'd15, 4'd3, 4'd2}) begin
      n_fail++;
      $display("FAIL counters: got lu/fl/mw=%0d/%0d/%0d expected 15/3/2", lu_cnt, fl_cnt, mw_cnt);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({lu_cnt, fl_cnt, mw_cnt} !== 12'd0) begin
      n_fail++;
      $display("FAIL counters_reset: got lu/fl/mw=%0d/%0d/%0d expected 0/0/0",
               lu_cnt, fl_cnt, mw_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_random();
`ifdef STALL_CNT_EN
    test_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
